// File: rtl/clock_pkg.sv
// Shared types and constants for the digital-clock timebase.
// The counter-width helper keeps degenerate moduli at one bit.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10,
    ST_ALARM   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  localparam int MS_PER_SEC = 1000;

  function automatic int cnt_w(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Key auto-repeat: one pulse on press, one after REP_DELAY_MS, then one every REP_RATE_MS.
// Releasing the key drops straight back to IDLE and suppresses any coincident pulse.
module key_repeat
  import clock_pkg::*;
#(
  parameter int REP_DELAY_MS = 500,
  parameter int REP_RATE_MS  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_stb,
  input  logic btn_held,
  output logic tick_rep
);

  localparam int REP_MAX = (REP_DELAY_MS > REP_RATE_MS) ? REP_DELAY_MS : REP_RATE_MS;
  localparam int REP_W   = cnt_w(REP_MAX);

  rep_state_t       st, st_nxt;
  logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
  logic             rep_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      rep_cnt  <= '0;
      tick_rep <= 1'b0;
    end else begin
      st       <= st_nxt;
      rep_cnt  <= rep_cnt_nxt;
      tick_rep <= rep_nxt;
    end
  end

  always_comb begin
    st_nxt      = st;
    rep_cnt_nxt = rep_cnt;
    rep_nxt     = 1'b0;
    if (!btn_held) begin
      st_nxt      = IDLE;
      rep_cnt_nxt = '0;
    end else begin
      case (st)
        IDLE: begin
          st_nxt      = DELAY;
          rep_cnt_nxt = '0;
          rep_nxt     = 1'b1;
        end
        DELAY: if (ms_stb) begin
          if (rep_cnt == REP_W'(REP_DELAY_MS - 1)) begin
            st_nxt      = REPEAT;
            rep_cnt_nxt = '0;
            rep_nxt     = 1'b1;
          end else begin
            rep_cnt_nxt = rep_cnt + REP_W'(1);
          end
        end
        REPEAT: if (ms_stb) begin
          if (rep_cnt == REP_W'(REP_RATE_MS - 1)) begin
            rep_cnt_nxt = '0;
            rep_nxt     = 1'b1;
          end else begin
            rep_cnt_nxt = rep_cnt + REP_W'(1);
          end
        end
        default: begin
          st_nxt      = IDLE;
          rep_cnt_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Clock timebase: 1 ms prescaler, second phase/tick, display blink and key auto-repeat.
// sec_clr realigns everything phase-related; SET modes freeze the second chain.
module tick_gen
  import clock_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BLINK_MS     = 500,
  parameter int REP_DELAY_MS = 500,
  parameter int REP_RATE_MS  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  state_t     state,
  input  logic       sec_clr,
  input  logic       btn_held,
  output logic       tick_ms,
  output logic       tick_sec,
  output logic [9:0] sec_phase,
  output logic       blink,
  output logic       tick_rep
);

  localparam int DIV_MS     = CLK_HZ / 1000;
  localparam int PRE_W      = cnt_w(DIV_MS);
  localparam int BLINK_HALF = BLINK_MS / 2;
  localparam int BL_W       = cnt_w(BLINK_HALF);

  if (CLK_HZ % 1000 != 0) begin : g_bad_clk
    $error("tick_gen: CLK_HZ must be a multiple of 1000");
  end
  if (DIV_MS < 2) begin : g_bad_div
    $error("tick_gen: CLK_HZ/1000 must be at least 2");
  end
  if (BLINK_MS < 2 || (BLINK_MS % 2) != 0) begin : g_bad_blink
    $error("tick_gen: BLINK_MS must be even and >= 2");
  end
  if (REP_DELAY_MS < 1 || REP_RATE_MS < 1) begin : g_bad_rep
    $error("tick_gen: repeat intervals must be >= 1 ms");
  end

  logic [PRE_W-1:0] pre_cnt;
  logic [BL_W-1:0]  blink_cnt;
  state_t           state_q;
  logic             phase_hold;
  logic             ms_stb, is_set, set_entry, rep_stb;

  assign ms_stb    = (pre_cnt == PRE_W'(DIV_MS - 1));
  assign is_set    = (state == ST_SET_HR) || (state == ST_SET_MIN);
  assign set_entry = is_set && (state != state_q);
  assign rep_stb   = ms_stb && !sec_clr;

  // phase_hold makes the first strobe after leaving a SET mode the phase origin,
  // so the next tick_sec lands a full 1000 ms after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt    <= '0;
      sec_phase  <= '0;
      tick_ms    <= 1'b0;
      tick_sec   <= 1'b0;
      blink      <= 1'b1;
      blink_cnt  <= '0;
      state_q    <= ST_RUN;
      phase_hold <= 1'b0;
    end else begin
      state_q <= state;
      if (sec_clr) begin
        pre_cnt    <= '0;
        sec_phase  <= '0;
        tick_ms    <= 1'b0;
        tick_sec   <= 1'b0;
        phase_hold <= is_set;
      end else begin
        pre_cnt  <= ms_stb ? '0 : pre_cnt + PRE_W'(1);
        tick_ms  <= ms_stb;
        tick_sec <= 1'b0;
        if (is_set) begin
          sec_phase  <= '0;
          phase_hold <= 1'b1;
        end else if (ms_stb) begin
          if (phase_hold) begin
            phase_hold <= 1'b0;
          end else if (sec_phase == 10'(MS_PER_SEC - 1)) begin
            sec_phase <= '0;
            tick_sec  <= 1'b1;
          end else begin
            sec_phase <= sec_phase + 10'd1;
          end
        end
      end

      if (set_entry) begin
        blink_cnt <= '0;
        blink     <= 1'b1;
      end else if (ms_stb && !sec_clr) begin
        if (blink_cnt == BL_W'(BLINK_HALF - 1)) begin
          blink_cnt <= '0;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt + BL_W'(1);
        end
      end
    end
  end

  key_repeat #(
    .REP_DELAY_MS(REP_DELAY_MS),
    .REP_RATE_MS (REP_RATE_MS)
  ) u_key_repeat (
    .clk     (clk),
    .rst     (rst),
    .ms_stb  (rep_stb),
    .btn_held(btn_held),
    .tick_rep(tick_rep)
  );

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen at CLK_HZ=10_000 (10 cycles per ms).
// Edges are counted from reset release; tick_sec/tick_rep are scoreboarded by edge number.
module tb_tick_gen;
  import clock_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_clr = 1'b0;
  logic       btn_held = 1'b0;
  state_t     state = ST_RUN;
  logic       tick_ms, tick_sec, blink, tick_rep;
  logic [9:0] sec_phase;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int sec_q[$];
  int rep_q[$];

  typedef struct {
    int e;
    bit ms;
    bit sec;
    int ph;
    bit blk;
  } vec_t;

  always #5 clk = ~clk;

  tick_gen #(
    .CLK_HZ      (10_000),
    .BLINK_MS    (500),
    .REP_DELAY_MS(500),
    .REP_RATE_MS (100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .sec_clr  (sec_clr),
    .btn_held (btn_held),
    .tick_ms  (tick_ms),
    .tick_sec (tick_sec),
    .sec_phase(sec_phase),
    .blink    (blink),
    .tick_rep (tick_rep)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc - t0, act, exp);
    end
  endtask

  // Advance to just after relative edge rel (inputs driven here are sampled at rel+1).
  task automatic goto(input int rel);
    while (cyc < t0 + rel) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tick_ms"}, int'(tick_ms), 0);
    chk({tag, "_tick_sec"}, int'(tick_sec), 0);
    chk({tag, "_sec_phase"}, int'(sec_phase), 0);
    chk({tag, "_blink"}, int'(blink), 1);
    chk({tag, "_tick_rep"}, int'(tick_rep), 0);
  endtask

  // Scoreboard: each tick_sec/tick_rep must match the queue head edge exactly.
  always @(posedge clk) begin
    bit due;
    #1;
    cyc++;
    due = (sec_q.size() > 0) && (sec_q[0] == cyc);
    if (due || tick_sec) chk("tick_sec_event", int'(tick_sec), int'(due));
    if (due) void'(sec_q.pop_front());
    due = (rep_q.size() > 0) && (rep_q[0] == cyc);
    if (due || tick_rep) chk("tick_rep_event", int'(tick_rep), int'(due));
    if (due) void'(rep_q.pop_front());
  end

  initial begin
    vec_t vt[10];
    int   be[6];
    bit   bb[6];
    vt = '{'{9, 0, 0, 0, 1}, '{10, 1, 0, 1, 1}, '{11, 0, 0, 1, 1}, '{20, 1, 0, 2, 1},
           '{2499, 0, 0, 249, 1}, '{2500, 1, 0, 250, 0}, '{5000, 1, 0, 500, 1},
           '{9999, 0, 0, 999, 0}, '{10000, 1, 1, 0, 1}, '{10001, 0, 0, 0, 1}};
    be = '{39519, 39520, 42019, 42020, 44519, 44520};
    bb = '{1, 0, 0, 1, 1, 0};

    repeat (3) @(posedge clk);
    #2;
    chk_reset("reset");
    rst = 1'b0;
    t0  = cyc;
    sec_q.push_back(t0 + 10000);

    // Free-running timebase from reset release
    for (int i = 0; i < 10; i++) begin
      goto(vt[i].e);
      chk("tbl_tick_ms", int'(tick_ms), int'(vt[i].ms));
      chk("tbl_tick_sec", int'(tick_sec), int'(vt[i].sec));
      chk("tbl_sec_phase", int'(sec_phase), vt[i].ph);
      chk("tbl_blink", int'(blink), int'(vt[i].blk));
    end

    // sec_clr at phase 700 coinciding with a strobe
    goto(17009);
    sec_clr = 1'b1;
    sec_q.push_back(t0 + 27010);
    goto(17010);
    sec_clr = 1'b0;
    chk("clr_tick_ms", int'(tick_ms), 0);
    chk("clr_sec_phase", int'(sec_phase), 0);
    goto(17020);
    chk("clr_next_ms", int'(tick_ms), 1);
    chk("clr_next_phase", int'(sec_phase), 1);
    goto(27009);
    chk("clr_phase_999", int'(sec_phase), 999);

    // sec_clr on the phase-999 strobe: no tick_sec
    goto(37009);
    chk("wrap_phase_999", int'(sec_phase), 999);
    sec_clr = 1'b1;
    goto(37010);
    sec_clr = 1'b0;
    chk("wrap_clr_tick_sec", int'(tick_sec), 0);
    chk("wrap_clr_tick_ms", int'(tick_ms), 0);
    chk("wrap_clr_phase", int'(sec_phase), 0);

    // SET_HR: phase frozen, blink restarts and toggles every 2500 cycles
    goto(37022);
    state = ST_SET_HR;
    goto(37023);
    chk("set_entry_blink", int'(blink), 1);
    chk("set_entry_phase", int'(sec_phase), 0);
    for (int i = 0; i < 6; i++) begin
      goto(be[i]);
      chk("set_blink", int'(blink), int'(bb[i]));
      chk("set_phase", int'(sec_phase), 0);
    end
    goto(45000);
    state = ST_SET_MIN;
    goto(45001);
    chk("hr_min_blink", int'(blink), 1);
    goto(45002);
    state = ST_RUN;
    sec_q.push_back(t0 + 55010);
    goto(45010);
    chk("run_first_ms", int'(tick_ms), 1);
    chk("run_first_phase", int'(sec_phase), 0);
    goto(45020);
    chk("run_second_phase", int'(sec_phase), 1);
    goto(55009);
    chk("run_phase_999", int'(sec_phase), 999);

    // Auto-repeat, held in SET_HR so the second chain stays quiet
    goto(55012);
    state = ST_SET_HR;
    goto(55019);
    btn_held = 1'b1;
    rep_q.push_back(t0 + 55020);
    for (int k = 0; k < 5; k++) rep_q.push_back(t0 + 60020 + 1000 * k);
    goto(64719);
    btn_held = 1'b0;
    goto(65500);
    btn_held = 1'b1;
    rep_q.push_back(t0 + 65501);

    // Reset mid-operation with key held and blink low
    goto(67599);
    chk("pre_rst_blink", int'(blink), 0);
    rst = 1'b1;
    goto(67600);
    chk_reset("mid_rst");
    goto(67601);
    rst = 1'b0;
    rep_q.push_back(t0 + 67602);
    goto(67610);
    btn_held = 1'b0;
    goto(67700);

    chk("sec_q_drained", sec_q.size(), 0);
    chk("rep_q_drained", rep_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
